imem_loader: RTL
================

Name: imem_loader

Overview:
- Stimulus-side counterpart to the register-dump logger. The logger reads CPU state out; this block writes a program into the CPU's instruction memory from a byte stream.
- Holds the CPU in reset while loading. Receives a length-prefixed, checksummed byte stream and writes 32-bit words to instruction memory at byte addresses 0, 4, 8, ...
- Releases the CPU only after a verified load.
- Sits between the bench/host byte source and Instr_Memory plus the CPU reset input.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest accepted program length; must be <= 2**ADDR_W.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse that begins a load.
- byte_i  in  8  stream byte.
- byte_valid_i  in  1  byte_i is valid.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- mem_we_o  out  1  instruction-memory write strobe.
- mem_addr_o  out  ADDR_W+2  byte address; always a multiple of 4.
- mem_data_o  out  32  write data.
- cpu_rst_o  out  1  active-low reset to the CPU. 0 holds the CPU; 1 lets it run.
- busy_o  out  1  load in progress.
- done_o  out  1  sticky: load verified.
- err_o  out  1  sticky: load rejected.
- words_o  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (rst_i=0, asynchronous)
  - State returns to IDLE.
  - All outputs go to 0, including cpu_rst_o=0, so the CPU is held.
  - Internal counters, shift register and checksum clear.
  - Memory already written is not erased.
- Handshake
  - A byte transfers on a rising edge with byte_valid_i=1 and byte_ready_o=1.
  - byte_ready_o is 1 only in LEN_LO, LEN_HI, DATA and CSUM. It is combinational from state.
  - byte_valid_i gaps of any length stall the FSM without side effects.
- State IDLE / DONE / ERR
  - start_i=1 clears words_o, done_o, err_o and the checksum, sets cpu_rst_o=0 and busy_o=1, then goes to LEN_LO.
  - start_i is ignored in all other states.
- State LEN_LO → LEN_HI
  - Assembles a 16-bit length L, little-endian.
  - After LEN_HI: L==0 or L>MAX_WORDS goes to ERR. Otherwise it goes to DATA with word index 0 and byte count 0.
- State DATA
  - Collects 4 bytes, little-endian: first byte → data[7:0], fourth → data[31:24].
  - Each data byte is XORed into the 8-bit checksum. Length bytes are excluded.
  - After the 4th byte goes to WRITE.
- State WRITE (exactly 1 cycle, byte_ready_o=0)
  - mem_we_o=1, mem_addr_o = index*4, mem_data_o = assembled word.
  - On exit: index++ and words_o++.
  - If index+1 == L goes to CSUM, else back to DATA.
  - Outputs are registered, so the strobe appears in the cycle after the 4th byte is accepted.
  - mem_we_o is 0 in every other state. mem_addr_o and mem_data_o hold their last values.
- State CSUM
  - Accepts 1 byte.
  - Equal to the running XOR → DONE: done_o=1, busy_o=0, cpu_rst_o=1 on the next cycle.
  - Not equal → ERR.
- State ERR
  - err_o=1, busy_o=0, cpu_rst_o stays 0.
  - Words already written remain in memory; words_o shows how many.
- Timing
  - Minimum 5 cycles per word (4 accepts + 1 write).
  - A full load takes >= 2 + 5L + 1 cycles after start.
- Widths
  - Index and words_o wrap-free, because L <= MAX_WORDS.
  - mem_addr_o = {index[ADDR_W-1:0], 2'b00}.
- Invariant: cpu_rst_o and done_o are always equal after reset.

Test Plan:
- Good load
  - Stimulus: start, bytes 02 00 | 05 00 01 20 | 0A 00 02 20 | 0C.
  - Response: writes (0x000, 0x20010005) then (0x004, 0x2002000A); words_o=2; done_o=1; cpu_rst_o=1; err_o=0.
- Zero length
  - Stimulus: start, bytes 00 00.
  - Response: err_o=1 one cycle after LEN_HI; no mem_we_o; cpu_rst_o=0.
- Over-length (MAX_WORDS=256)
  - Stimulus: start, bytes 01 01 (L=257).
  - Response: err_o=1; no writes.
- Bad checksum
  - Stimulus: good-load sequence with final byte 0D.
  - Response: both words written; words_o=2; err_o=1; done_o=0; cpu_rst_o=0.
- Stalls
  - Stimulus: good-load sequence with random 0–5 cycle valid gaps and start_i pulsed mid-load.
  - Response: identical writes and result; mid-load start ignored; byte_ready_o=0 in every WRITE cycle.
- Reset and restart
  - Stimulus: rst_i=0 after the first write.
  - Response: all outputs 0 asynchronously and state IDLE.
  - Stimulus: then start and the good-load sequence.
  - Response: done_o=1.
  - Stimulus: then start again.
  - Response: cpu_rst_o=0 and done_o=0 on the next cycle.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus between a host byte source and imem_loader.
// Signal names are from the loader's point of view.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W+1:0] mem_addr_o;
    logic [31:0]       mem_data_o;

    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and holds the
// CPU in reset until the load has been verified.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    imem_loader_if.slave    bus,
    output logic            cpu_rst_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [ADDR_W:0] words_o
);

    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StWrite, StCsum, StDone, StErr
    } state_e;

    state_e            state_q;
    logic [15:0]       len_q;
    logic [1:0]        cnt_q;
    logic [23:0]       shift_q;
    logic [7:0]        csum_q;
    logic [ADDR_W:0]   words_q;
    logic              we_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       data_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              ready;
    logic              accept;
    logic [15:0]       len_full;
    logic              len_bad;
    logic [ADDR_W:0]   words_inc;
    logic              last_word;

    assign ready = (state_q == StLenLo) || (state_q == StLenHi) ||
                   (state_q == StData)  || (state_q == StCsum);
    assign accept = bus.byte_valid_i && ready;

    assign len_full  = {bus.byte_i, len_q[7:0]};
    assign len_bad   = (len_full == 16'd0) || ({16'd0, len_full} > MAX_WORDS);
    assign words_inc = words_q + 1'b1;
    // words_q doubles as the write index, so the last word is when the incremented count hits L
    assign last_word = (16'(words_inc) == len_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            csum_q  <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start_i) begin
                        words_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        csum_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (accept) begin
                        len_q[7:0] <= bus.byte_i;
                        state_q    <= StLenHi;
                    end
                end
                StLenHi: begin
                    if (accept) begin
                        len_q[15:8] <= bus.byte_i;
                        cnt_q       <= '0;
                        if (len_bad) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StErr;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        csum_q <= csum_q ^ bus.byte_i;
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            addr_q  <= {words_q[ADDR_W-1:0], 2'b00};
                            data_q  <= {bus.byte_i, shift_q};
                            state_q <= StWrite;
                        end else begin
                            shift_q <= {bus.byte_i, shift_q[23:8]};
                        end
                    end
                end
                StWrite: begin
                    words_q <= words_inc;
                    state_q <= last_word ? StCsum : StData;
                end
                StCsum: begin
                    if (accept) begin
                        busy_q <= 1'b0;
                        if (bus.byte_i == csum_q) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StErr;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.byte_ready_o = ready;
    assign bus.mem_we_o     = we_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_data_o   = data_q;
    // CPU runs exactly when a verified load is being reported
    assign cpu_rst_o        = done_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign words_o          = words_q;

endmodule
